// File: rtl/edge_scan_if.sv
// Pixel-raster handshake bundle between the pixel source, the scan controller
// and the convolution stage.
interface edge_scan_if #(
  parameter int unsigned COL_WIDTH = 10,
  parameter int unsigned ROW_WIDTH = 9
);
  logic                 start;
  logic                 abort;
  logic                 in_valid;
  logic                 in_ready;
  logic                 line_shift;
  logic [COL_WIDTH-1:0] col;
  logic [ROW_WIDTH-1:0] row;
  logic                 out_valid;
  logic                 out_ready;
  logic [COL_WIDTH-1:0] win_col;
  logic [ROW_WIDTH-1:0] win_row;
  logic                 busy;
  logic                 frame_done;

  modport master (
    input  start, abort, in_valid, out_ready,
    output in_ready, line_shift, col, row, out_valid, win_col, win_row,
           busy, frame_done
  );

  modport slave (
    output start, abort, in_valid, out_ready,
    input  in_ready, line_shift, col, row, out_valid, win_col, win_row,
           busy, frame_done
  );
endinterface

// File: rtl/edge_scan_controller.sv
// Raster sequencer for the edge-detection kernel: tracks the incoming pixel
// position, drives the line-buffer shift and publishes KERNEL x KERNEL window centres.
module edge_scan_controller #(
  parameter int unsigned IMG_WIDTH  = 640,
  parameter int unsigned IMG_HEIGHT = 480,
  parameter int unsigned COL_WIDTH  = 10,
  parameter int unsigned ROW_WIDTH  = 9,
  parameter int unsigned KERNEL     = 3
) (
  input  logic          clock,
  input  logic          reset,
  edge_scan_if.master   bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] PRIME = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [COL_WIDTH-1:0] COL_LAST  = COL_WIDTH'(IMG_WIDTH - 1);
  localparam logic [COL_WIDTH-1:0] COL_EDGE  = COL_WIDTH'(KERNEL - 1);
  localparam logic [COL_WIDTH-1:0] COL_HALF  = COL_WIDTH'((KERNEL - 1) / 2);
  localparam logic [ROW_WIDTH-1:0] ROW_LAST  = ROW_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_PRIME = ROW_WIDTH'(KERNEL - 2);
  localparam logic [ROW_WIDTH-1:0] ROW_EDGE  = ROW_WIDTH'(KERNEL - 1);
  localparam logic [ROW_WIDTH-1:0] ROW_HALF  = ROW_WIDTH'((KERNEL - 1) / 2);

  logic [2:0]           state;
  logic [2:0]           state_nx;
  logic [COL_WIDTH-1:0] col_q;
  logic [ROW_WIDTH-1:0] row_q;
  logic [COL_WIDTH-1:0] win_col_q;
  logic [ROW_WIDTH-1:0] win_row_q;
  logic                 out_valid_q;
  logic                 in_ready;
  logic                 accept;
  logic                 col_last;
  logic                 row_last;
  logic                 win_hit;

  // Input stalls while an unconsumed window is pending, so no window is overwritten.
  assign in_ready = ((state == PRIME) || (state == RUN)) && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign win_hit  = accept && (row_q >= ROW_EDGE) && (col_q >= COL_EDGE);

  always_comb begin
    state_nx = state;
    if (bus.abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_nx = PRIME;
        PRIME:   if (accept && col_last && (row_q == ROW_PRIME)) state_nx = RUN;
        RUN:     if (accept && col_last && row_last) state_nx = DRAIN;
        DRAIN:   if (!out_valid_q || bus.out_ready) state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      col_q <= '0;
      row_q <= '0;
    end else begin
      state <= state_nx;
      if (bus.abort) begin
        col_q <= '0;
        row_q <= '0;
      end else if (accept) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      win_col_q   <= '0;
      win_row_q   <= '0;
    end else if (bus.abort) begin
      out_valid_q <= 1'b0;
    end else if (win_hit) begin
      out_valid_q <= 1'b1;
      win_col_q   <= col_q - COL_HALF;
      win_row_q   <= row_q - ROW_HALF;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.line_shift = accept;
  assign bus.col        = col_q;
  assign bus.row        = row_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.win_col    = win_col_q;
  assign bus.win_row    = win_row_q;
  assign bus.busy       = (state != IDLE);
  assign bus.frame_done = (state == DONE);

endmodule
